// File: rtl/reflet_write_checker.sv
// reflet_write_checker
//
// Self-checking sink for the Reflet CPU data bus. The program writes its results one word at a
// time to the data port; each write is compared, in order, against the expected sequence in
// seq_content. The verdict (pass/fail) and the index of the first bad write are latched, and a
// status word can be read back so the program can see its own verdict.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; wins over any bus access in the same cycle
//   addr         word address from the CPU
//   data_in      CPU write data
//   write_en     write strobe, qualified by addr
//   data_out     registered read data, 0 when not selected (safe to OR onto the bus)
//   done         verdict reached (PASS or FAIL)
//   pass         full sequence matched
//   error_index  index of the first failing write, 0xFF if none
//
// Address map: base_addr = data port, base_addr+1 = status port (write re-arms).
// Status word: bit0 done, bit1 pass, bit2 fail, bit3 (state != IDLE), bits[15:8] cnt.
// The status layout needs word_size >= 16.

module reflet_write_checker #(
    parameter int unsigned                    addr_size   = 15,
    parameter logic [addr_size-1:0]           base_addr   = 15'h4A00,
    parameter int unsigned                    word_size   = 16,
    parameter int unsigned                    seq_len     = 8,
    parameter logic [seq_len*word_size-1:0]   seq_content = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [addr_size-1:0] addr,
    input  logic [word_size-1:0] data_in,
    input  logic                 write_en,
    output logic [word_size-1:0] data_out,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           error_index
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StPass = 2'd2;
    localparam logic [1:0] StFail = 2'd3;

    localparam logic [addr_size-1:0] DataAddr = base_addr;
    localparam logic [addr_size-1:0] StatAddr = base_addr + 1'b1;

    logic [1:0]           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           err_idx_q, err_idx_d;
    logic [word_size-1:0] data_out_q, data_out_d;

    logic                 sel_data, sel_stat;
    logic [word_size-1:0] exp_word;
    logic [word_size-1:0] status_word;
    logic [8:0]           cnt_inc;

    // Unpack the expected sequence; element 0 sits in the most significant word.
    logic [word_size-1:0] exp_mem [seq_len];

    for (genvar i = 0; i < seq_len; i++) begin : g_exp
        assign exp_mem[i] = seq_content[(seq_len-1-i)*word_size +: word_size];
    end

    assign sel_data = (addr == DataAddr);
    assign sel_stat = (addr == StatAddr);

    // cnt only reaches seq_len in PASS, where the expected word is never used.
    always_comb begin
        exp_word = '0;
        for (int i = 0; i < seq_len; i++) begin
            if (cnt_q == 8'(i)) begin
                exp_word = exp_mem[i];
            end
        end
    end

    assign done = (state_q == StPass) || (state_q == StFail);
    assign pass = (state_q == StPass);

    always_comb begin
        status_word       = '0;
        status_word[0]    = done;
        status_word[1]    = pass;
        status_word[2]    = (state_q == StFail);
        status_word[3]    = (state_q != StIdle);
        status_word[15:8] = cnt_q;
    end

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    // Next state for a bus write.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_idx_d = err_idx_q;

        if (write_en && sel_data) begin
            case (state_q)
                StIdle, StRun: begin
                    if (data_in == exp_word) begin
                        cnt_d   = cnt_inc[7:0];
                        state_d = (cnt_inc == 9'(seq_len)) ? StPass : StRun;
                    end else begin
                        state_d   = StFail;
                        err_idx_d = cnt_q;
                    end
                end
                StPass: begin
                    // One write too many.
                    state_d   = StFail;
                    err_idx_d = 8'(seq_len);
                end
                default: ; // FAIL is sticky
            endcase
        end else if (write_en && sel_stat) begin
            state_d   = StIdle;
            cnt_d     = '0;
            err_idx_d = 8'hFF;
        end
    end

    // Read data reflects the state before this edge's update; writes never return data.
    always_comb begin
        data_out_d = '0;
        if (!write_en) begin
            if (sel_data) begin
                if ((state_q == StIdle) || (state_q == StRun)) begin
                    data_out_d = exp_word;
                end
            end else if (sel_stat) begin
                data_out_d = status_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            err_idx_q  <= 8'hFF;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_idx_q  <= err_idx_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out    = data_out_q;
    assign error_index = err_idx_q;

endmodule

// File: tb/tb_reflet_write_checker.sv
module tb_reflet_write_checker;

    localparam logic [14:0] DataAddr = 15'h4A00;
    localparam logic [14:0] StatAddr = 15'h4A01;

    logic        clk;
    logic        reset;
    logic [14:0] addr;
    logic [15:0] data_in;
    logic        write_en;
    logic [15:0] data_out;
    logic        done;
    logic        pass;
    logic [7:0]  error_index;

    int total;
    int bad;

    reflet_write_checker #(
        .addr_size   (15),
        .base_addr   (15'h4A00),
        .word_size   (16),
        .seq_len     (3),
        .seq_content (48'h0006_0C80_0019)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .data_in     (data_in),
        .write_en    (write_en),
        .data_out    (data_out),
        .done        (done),
        .pass        (pass),
        .error_index (error_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one bus cycle starting at a falling edge; returns at the next falling edge, after the
    // rising edge that sampled it, so registered outputs can be checked directly.
    task automatic bus_cycle(input logic rst, input logic [14:0] a, input logic [15:0] d,
                             input logic we);
        reset    = rst;
        addr     = a;
        data_in  = d;
        write_en = we;
        @(negedge clk);
        reset    = 1'b0;
        addr     = 15'h0000;
        data_in  = 16'h0000;
        write_en = 1'b0;
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        bus_cycle(1'b0, a, d, 1'b1);
    endtask

    task automatic rd(input logic [14:0] a);
        bus_cycle(1'b0, a, 16'h0000, 1'b0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        addr     = '0;
        data_in  = '0;
        write_en = 1'b0;
        @(negedge clk);
        bus_cycle(1'b1, 15'h0000, 16'h0000, 1'b0);

        // Reset state
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_err", error_index, 8'hFF);
        check_eq("rst_dout", data_out, 0);
        rd(StatAddr);
        check_eq("rst_status", data_out, 16'h0000);
        rd(DataAddr);
        check_eq("idle_expect0", data_out, 16'h0006);

        // Full matching sequence, back-to-back
        wr(DataAddr, 16'h0006);
        check_eq("w1_dout_zero", data_out, 0);
        wr(DataAddr, 16'h0C80);
        wr(DataAddr, 16'h0019);
        check_eq("pass_pass", pass, 1);
        check_eq("pass_done", done, 1);
        check_eq("pass_err", error_index, 8'hFF);
        rd(StatAddr);
        check_eq("pass_status", data_out, 16'h030B);
        rd(DataAddr);
        check_eq("pass_data_rd", data_out, 0);

        // Re-arm, then mismatch on the second write
        wr(StatAddr, 16'hBEEF);
        check_eq("rearm_done", done, 0);
        check_eq("rearm_err", error_index, 8'hFF);
        rd(StatAddr);
        check_eq("rearm_status", data_out, 16'h0000);
        wr(DataAddr, 16'h0006);
        wr(DataAddr, 16'h0C81);
        check_eq("mm_err", error_index, 1);
        check_eq("mm_pass", pass, 0);
        check_eq("mm_done", done, 1);
        rd(StatAddr);
        check_eq("mm_status", data_out, 16'h010D);
        wr(DataAddr, 16'h0019);
        check_eq("sticky_err", error_index, 1);
        rd(StatAddr);
        check_eq("sticky_status", data_out, 16'h010D);
        rd(DataAddr);
        check_eq("fail_data_rd", data_out, 0);

        // Overflow after a complete sequence
        wr(StatAddr, 16'h0000);
        wr(DataAddr, 16'h0006);
        wr(DataAddr, 16'h0C80);
        wr(DataAddr, 16'h0019);
        wr(DataAddr, 16'h0000);
        check_eq("ovf_err", error_index, 3);
        check_eq("ovf_pass", pass, 0);
        rd(StatAddr);
        check_eq("ovf_status", data_out, 16'h030D);

        // Reset in the same cycle as a correct write at cnt=2
        wr(StatAddr, 16'h0000);
        wr(DataAddr, 16'h0006);
        wr(DataAddr, 16'h0C80);
        rd(StatAddr);
        check_eq("mid_status", data_out, 16'h0208);
        rd(DataAddr);
        check_eq("mid_expect2", data_out, 16'h0019);
        bus_cycle(1'b1, DataAddr, 16'h0019, 1'b1);
        check_eq("rstw_done", done, 0);
        check_eq("rstw_err", error_index, 8'hFF);
        check_eq("rstw_dout", data_out, 0);
        rd(StatAddr);
        check_eq("rstw_status", data_out, 16'h0000);

        // Fail at index 0, then re-arm via status write
        wr(DataAddr, 16'h0001);
        check_eq("f0_err", error_index, 0);
        check_eq("f0_done", done, 1);
        wr(StatAddr, 16'h1234);
        rd(DataAddr);
        check_eq("rearm_data_rd", data_out, 16'h0006);
        check_eq("rearm2_err", error_index, 8'hFF);

        // Other addresses have no effect
        rd(15'h4000);
        check_eq("rd_4000", data_out, 0);
        rd(15'h4A02);
        check_eq("rd_4A02", data_out, 0);
        wr(15'h4000, 16'h0006);
        wr(15'h4A02, 16'h0006);
        check_eq("other_done", done, 0);
        rd(StatAddr);
        check_eq("other_status", data_out, 16'h0000);
        wr(DataAddr, 16'h0006);
        rd(StatAddr);
        check_eq("after_other_status", data_out, 16'h0108);
        rd(15'h0000);
        check_eq("idle_bus_zero", data_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
